// File: rtl/pcie_rq_arbiter.sv
// pcie_rq_arbiter
// Packet-granular two-input arbiter in front of the PCIe core RQ AXI-stream.
// Port 0 carries user requests, port 1 carries ATS invalidation completions.
// Whole TLPs are granted; beats of different packets are never interleaved.
// A one-cycle IDLE bubble separates consecutive packets.
//
// Optional build macro:
//   RQ_ARB_ATS_PRIO_EN - on a tie in IDLE, port 1 always wins.
//                        Without it, ties are resolved round-robin against
//                        last_served.
//
// Handshake: strict AXI-stream valid/ready. A beat transfers on a rising
// edge where tvalid && tready are both high. Sources hold tvalid and payload
// stable until accepted. The granted port's tready equals m_axis_tready
// combinationally. The non-granted port's tready is 0, and both treadys are 0
// in IDLE. grant (registered decode of the FSM state) exposes the arbiter
// state for debug.

module pcie_rq_arbiter #(
  parameter int AXIS_DATA_WIDTH = 512,
  parameter int RQ_AXIS_TUSER_W = 183,
  parameter int CNT_W           = 16
) (
  input  logic                         clk,
  input  logic                         rst,

  input  logic [AXIS_DATA_WIDTH-1:0]   s0_axis_tdata,
  input  logic [AXIS_DATA_WIDTH/8-1:0] s0_axis_tkeep,
  input  logic [RQ_AXIS_TUSER_W-1:0]   s0_axis_tuser,
  input  logic                         s0_axis_tlast,
  input  logic                         s0_axis_tvalid,
  output logic                         s0_axis_tready,

  input  logic [AXIS_DATA_WIDTH-1:0]   s1_axis_tdata,
  input  logic [AXIS_DATA_WIDTH/8-1:0] s1_axis_tkeep,
  input  logic [RQ_AXIS_TUSER_W-1:0]   s1_axis_tuser,
  input  logic                         s1_axis_tlast,
  input  logic                         s1_axis_tvalid,
  output logic                         s1_axis_tready,

  output logic [AXIS_DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [AXIS_DATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic [RQ_AXIS_TUSER_W-1:0]   m_axis_tuser,
  output logic                         m_axis_tlast,
  output logic                         m_axis_tvalid,
  input  logic                         m_axis_tready,

  output logic [1:0]                   grant,
  output logic [CNT_W-1:0]             pkt_cnt0,
  output logic [CNT_W-1:0]             pkt_cnt1
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GNT0 = 2'd1,
    ST_GNT1 = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             last_served_q, last_served_d;
  logic [CNT_W-1:0] pkt_cnt0_q, pkt_cnt0_d;
  logic [CNT_W-1:0] pkt_cnt1_q, pkt_cnt1_d;
  logic [1:0]       grant_q, grant_d;

  logic             s0_end;
  logic             s1_end;

  // A packet ends when the granted port's last beat is accepted by the core.
  assign s0_end = s0_axis_tvalid && m_axis_tready && s0_axis_tlast;
  assign s1_end = s1_axis_tvalid && m_axis_tready && s1_axis_tlast;

  // State, round-robin pointer, packet counters and grant decode registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      last_served_q <= 1'b1;
      pkt_cnt0_q    <= '0;
      pkt_cnt1_q    <= '0;
      grant_q       <= 2'b00;
    end else begin
      state_q       <= state_d;
      last_served_q <= last_served_d;
      pkt_cnt0_q    <= pkt_cnt0_d;
      pkt_cnt1_q    <= pkt_cnt1_d;
      grant_q       <= grant_d;
    end
  end

  // Next-state: arbitrate in IDLE, hold ownership until tlast is accepted.
  always_comb begin
    state_d       = state_q;
    last_served_d = last_served_q;
    pkt_cnt0_d    = pkt_cnt0_q;
    pkt_cnt1_d    = pkt_cnt1_q;
    case (state_q)
      ST_IDLE: begin
        if (s0_axis_tvalid && s1_axis_tvalid) begin
`ifdef RQ_ARB_ATS_PRIO_EN
          state_d = ST_GNT1;
`else
          state_d = last_served_q ? ST_GNT0 : ST_GNT1;
`endif
        end else if (s0_axis_tvalid) begin
          state_d = ST_GNT0;
        end else if (s1_axis_tvalid) begin
          state_d = ST_GNT1;
        end
      end
      ST_GNT0: begin
        if (s0_end) begin
          state_d       = ST_IDLE;
          last_served_d = 1'b0;
          pkt_cnt0_d    = pkt_cnt0_q + CNT_W'(1);
        end
      end
      ST_GNT1: begin
        if (s1_end) begin
          state_d       = ST_IDLE;
          last_served_d = 1'b1;
          pkt_cnt1_d    = pkt_cnt1_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // One-hot grant decode of the next state, registered so it tracks state_q.
  always_comb begin
    grant_d = 2'b00;
    case (state_d)
      ST_GNT0: grant_d = 2'b01;
      ST_GNT1: grant_d = 2'b10;
      default: grant_d = 2'b00;
    endcase
  end

  // Zero-latency datapath mux; everything idles at zero outside a grant.
  always_comb begin
    m_axis_tdata   = '0;
    m_axis_tkeep   = '0;
    m_axis_tuser   = '0;
    m_axis_tlast   = 1'b0;
    m_axis_tvalid  = 1'b0;
    s0_axis_tready = 1'b0;
    s1_axis_tready = 1'b0;
    case (state_q)
      ST_GNT0: begin
        m_axis_tdata   = s0_axis_tdata;
        m_axis_tkeep   = s0_axis_tkeep;
        m_axis_tuser   = s0_axis_tuser;
        m_axis_tlast   = s0_axis_tlast;
        m_axis_tvalid  = s0_axis_tvalid;
        s0_axis_tready = m_axis_tready;
      end
      ST_GNT1: begin
        m_axis_tdata   = s1_axis_tdata;
        m_axis_tkeep   = s1_axis_tkeep;
        m_axis_tuser   = s1_axis_tuser;
        m_axis_tlast   = s1_axis_tlast;
        m_axis_tvalid  = s1_axis_tvalid;
        s1_axis_tready = m_axis_tready;
      end
      default: begin
      end
    endcase
  end

  assign grant    = grant_q;
  assign pkt_cnt0 = pkt_cnt0_q;
  assign pkt_cnt1 = pkt_cnt1_q;

endmodule

// File: tb/tb_pcie_rq_arbiter.sv
// Directed bench for pcie_rq_arbiter. Inputs change 1 ns after the rising
// edge and outputs are sampled on the falling edge. Counters are built
// narrow (CW bits) so that wrap-around can be reached quickly.

module tb_pcie_rq_arbiter;

  localparam int DW = 512;
  localparam int KW = DW / 8;
  localparam int UW = 183;
  localparam int CW = 3;

  logic          clk;
  logic          rst;
  logic [DW-1:0] s0_axis_tdata, s1_axis_tdata, m_axis_tdata;
  logic [KW-1:0] s0_axis_tkeep, s1_axis_tkeep, m_axis_tkeep;
  logic [UW-1:0] s0_axis_tuser, s1_axis_tuser, m_axis_tuser;
  logic          s0_axis_tlast, s1_axis_tlast, m_axis_tlast;
  logic          s0_axis_tvalid, s1_axis_tvalid, m_axis_tvalid;
  logic          s0_axis_tready, s1_axis_tready, m_axis_tready;
  logic [1:0]    grant;
  logic [CW-1:0] pkt_cnt0, pkt_cnt1;

  int checks = 0;
  int errors = 0;

  pcie_rq_arbiter #(
    .AXIS_DATA_WIDTH (DW),
    .RQ_AXIS_TUSER_W (UW),
    .CNT_W           (CW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .s0_axis_tdata  (s0_axis_tdata),
    .s0_axis_tkeep  (s0_axis_tkeep),
    .s0_axis_tuser  (s0_axis_tuser),
    .s0_axis_tlast  (s0_axis_tlast),
    .s0_axis_tvalid (s0_axis_tvalid),
    .s0_axis_tready (s0_axis_tready),
    .s1_axis_tdata  (s1_axis_tdata),
    .s1_axis_tkeep  (s1_axis_tkeep),
    .s1_axis_tuser  (s1_axis_tuser),
    .s1_axis_tlast  (s1_axis_tlast),
    .s1_axis_tvalid (s1_axis_tvalid),
    .s1_axis_tready (s1_axis_tready),
    .m_axis_tdata   (m_axis_tdata),
    .m_axis_tkeep   (m_axis_tkeep),
    .m_axis_tuser   (m_axis_tuser),
    .m_axis_tlast   (m_axis_tlast),
    .m_axis_tvalid  (m_axis_tvalid),
    .m_axis_tready  (m_axis_tready),
    .grant          (grant),
    .pkt_cnt0       (pkt_cnt0),
    .pkt_cnt1       (pkt_cnt1)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [DW-1:0] mk_data(input int port, input int beat);
    logic [DW-1:0] d;
    d = '0;
    d[15:0] = 16'(port * 256 + beat);
    d[DW-1 -: 8] = 8'hA5;
    return d;
  endfunction

  function automatic logic [UW-1:0] mk_user(input int port, input int beat);
    logic [UW-1:0] u;
    u = '0;
    u[7:0] = 8'(port * 16 + beat);
    u[UW-1] = 1'b1;
    return u;
  endfunction

  task automatic drive0(input logic v, input int beat, input logic last);
    s0_axis_tvalid = v;
    s0_axis_tdata  = mk_data(0, beat);
    s0_axis_tkeep  = '1;
    s0_axis_tuser  = mk_user(0, beat);
    s0_axis_tlast  = last;
  endtask

  task automatic drive1(input logic v, input int beat, input logic last);
    s1_axis_tvalid = v;
    s1_axis_tdata  = mk_data(1, beat);
    s1_axis_tkeep  = '1;
    s1_axis_tuser  = mk_user(1, beat);
    s1_axis_tlast  = last;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    m_axis_tready = 1'b1;
    drive0(1'b0, 0, 1'b0);
    drive1(1'b0, 0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL reset_grant: got %b want 00", grant); end
    checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL reset_m_tvalid: got %b want 0", m_axis_tvalid); end
    checks++; if (m_axis_tdata !== '0) begin errors++; $display("FAIL reset_m_tdata: got %h want 0", m_axis_tdata[31:0]); end
    checks++; if ({s0_axis_tready, s1_axis_tready} !== 2'b00) begin errors++; $display("FAIL reset_treadys: got %b want 00", {s0_axis_tready, s1_axis_tready}); end
    checks++; if (pkt_cnt0 !== 3'd0 || pkt_cnt1 !== 3'd0) begin errors++; $display("FAIL reset_cnts: got %0d/%0d want 0/0", pkt_cnt0, pkt_cnt1); end
  endtask

  task automatic test_single_beat_s1();
    step();
    drive1(1'b1, 0, 1'b1);
    @(negedge clk);
    checks++; if (grant !== 2'b00 || s1_axis_tready !== 1'b0 || m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL s1b_idle: got grant %b rdy %b vld %b want 00 0 0", grant, s1_axis_tready, m_axis_tvalid); end
    step();
    @(negedge clk);
    checks++; if (grant !== 2'b10) begin errors++; $display("FAIL s1b_grant: got %b want 10", grant); end
    checks++; if (m_axis_tvalid !== 1'b1 || m_axis_tlast !== 1'b1) begin errors++; $display("FAIL s1b_vld_last: got %b%b want 11", m_axis_tvalid, m_axis_tlast); end
    checks++; if (m_axis_tdata !== mk_data(1, 0) || m_axis_tuser !== mk_user(1, 0) || m_axis_tkeep !== {KW{1'b1}}) begin errors++; $display("FAIL s1b_payload: got %h want %h", m_axis_tdata[15:0], 16'h0100); end
    checks++; if (s1_axis_tready !== 1'b1 || s0_axis_tready !== 1'b0) begin errors++; $display("FAIL s1b_tready: got s0 %b s1 %b want 0 1", s0_axis_tready, s1_axis_tready); end
    step();
    drive1(1'b0, 0, 1'b0);
    @(negedge clk);
    checks++; if (grant !== 2'b00 || m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL s1b_back_idle: got grant %b vld %b want 00 0", grant, m_axis_tvalid); end
    checks++; if (pkt_cnt1 !== 3'd1 || pkt_cnt0 !== 3'd0) begin errors++; $display("FAIL s1b_cnts: got %0d/%0d want 0/1", pkt_cnt0, pkt_cnt1); end
  endtask

  task automatic test_hold_ownership();
    step();
    drive0(1'b1, 0, 1'b0);
    @(negedge clk);
    for (int b = 0; b < 4; b++) begin
      step();
      drive0(1'b1, b, (b == 3));
      if (b == 1) drive1(1'b1, 7, 1'b1);
      @(negedge clk);
      checks++; if (grant !== 2'b01 || s1_axis_tready !== 1'b0) begin errors++; $display("FAIL hold_grant_b%0d: got grant %b s1rdy %b want 01 0", b, grant, s1_axis_tready); end
      checks++; if (m_axis_tdata !== mk_data(0, b) || m_axis_tlast !== (b == 3)) begin errors++; $display("FAIL hold_beat_b%0d: got %h/%b want %h/%b", b, m_axis_tdata[15:0], m_axis_tlast, 16'(b), (b == 3)); end
    end
    step();
    drive0(1'b0, 0, 1'b0);
    @(negedge clk);
    checks++; if (grant !== 2'b00 || m_axis_tvalid !== 1'b0 || s1_axis_tready !== 1'b0) begin errors++; $display("FAIL hold_bubble: got grant %b vld %b want 00 0", grant, m_axis_tvalid); end
    checks++; if (pkt_cnt0 !== 3'd1) begin errors++; $display("FAIL hold_cnt0: got %0d want 1", pkt_cnt0); end
    step();
    @(negedge clk);
    checks++; if (grant !== 2'b10 || m_axis_tdata !== mk_data(1, 7) || s1_axis_tready !== 1'b1) begin errors++; $display("FAIL hold_then_s1: got grant %b data %h want 10 %h", grant, m_axis_tdata[15:0], 16'h0107); end
    step();
    drive1(1'b0, 0, 1'b0);
    @(negedge clk);
    checks++; if (grant !== 2'b00 || pkt_cnt1 !== 3'd2) begin errors++; $display("FAIL hold_s1_done: got grant %b cnt1 %0d want 00 2", grant, pkt_cnt1); end
  endtask

  task automatic test_tie_arbitration();
    logic [1:0] exp_g [13];
    logic acc0, acc1;
    int b0, b1;
`ifdef RQ_ARB_ATS_PRIO_EN
    exp_g = '{2'b00, 2'b10, 2'b10, 2'b00, 2'b10, 2'b10, 2'b00,
              2'b10, 2'b10, 2'b00, 2'b10, 2'b10, 2'b00};
`else
    exp_g = '{2'b00, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b00,
              2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b00};
`endif
    b0 = 0;
    b1 = 0;
    step();
    drive0(1'b1, 0, 1'b0);
    drive1(1'b1, 0, 1'b0);
    for (int k = 0; k < 13; k++) begin
      @(negedge clk);
      checks++; if (grant !== exp_g[k]) begin errors++; $display("FAIL tie_grant_c%0d: got %b want %b", k, grant, exp_g[k]); end
      acc0 = s0_axis_tvalid && s0_axis_tready;
      acc1 = s1_axis_tvalid && s1_axis_tready;
      if (k == 12) begin
        drive0(1'b0, 0, 1'b0);
        drive1(1'b0, 0, 1'b0);
      end else begin
        step();
        if (acc0) begin b0 = (b0 + 1) % 2; drive0(1'b1, b0, (b0 == 1)); end
        if (acc1) begin b1 = (b1 + 1) % 2; drive1(1'b1, b1, (b1 == 1)); end
      end
    end
`ifdef RQ_ARB_ATS_PRIO_EN
    checks++; if (pkt_cnt0 !== 3'd1 || pkt_cnt1 !== 3'd6) begin errors++; $display("FAIL tie_cnts: got %0d/%0d want 1/6", pkt_cnt0, pkt_cnt1); end
`else
    checks++; if (pkt_cnt0 !== 3'd3 || pkt_cnt1 !== 3'd4) begin errors++; $display("FAIL tie_cnts: got %0d/%0d want 3/4", pkt_cnt0, pkt_cnt1); end
`endif
  endtask

  task automatic test_ready_stall();
    logic [31:0] exp_q[$];
    logic [31:0] exp;
    logic        acc;
    int          rp [6];
    int          b;
    logic [CW-1:0] cnt_before;
    rp = '{1, 0, 0, 1, 1, 1};
    cnt_before = pkt_cnt0;
    exp_q.push_back(32'd0);
    exp_q.push_back(32'd1);
    exp_q.push_back(32'd2);
    acc = 1'b0;
    b = 0;
    step();
    m_axis_tready = 1'b1;
    drive0(1'b1, 0, 1'b0);
    @(negedge clk);
    for (int c = 0; c < 6; c++) begin
      step();
      if (acc) begin
        b++;
        if (b < 3) drive0(1'b1, b, (b == 2));
        else drive0(1'b0, 0, 1'b0);
      end
      m_axis_tready = rp[c][0];
      @(negedge clk);
      acc = s0_axis_tvalid && s0_axis_tready;
      if (m_axis_tvalid && m_axis_tready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL stall_extra_beat: got beat %h want none", m_axis_tdata[15:0]);
        end else begin
          exp = exp_q.pop_front();
          if (m_axis_tdata !== mk_data(0, int'(exp))) begin errors++; $display("FAIL stall_beat: got %h want %h", m_axis_tdata[15:0], exp[15:0]); end
        end
      end
      if (!m_axis_tready) begin
        checks++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== mk_data(0, 1) || s0_axis_tready !== 1'b0 || grant !== 2'b01) begin errors++; $display("FAIL stall_hold_c%0d: got vld %b data %h rdy %b want 1 0001 0", c, m_axis_tvalid, m_axis_tdata[15:0], s0_axis_tready); end
      end
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL stall_missing: got %0d beats left want 0", exp_q.size()); end
    checks++; if (grant !== 2'b00 || pkt_cnt0 !== cnt_before + 3'd1) begin errors++; $display("FAIL stall_end: got grant %b cnt0 %0d want 00 %0d", grant, pkt_cnt0, cnt_before + 3'd1); end
  endtask

  task automatic test_reset_mid_packet();
    step();
    drive1(1'b1, 0, 1'b0);
    @(negedge clk);
    step();
    @(negedge clk);
    checks++; if (grant !== 2'b10) begin errors++; $display("FAIL rstmid_grant: got %b want 10", grant); end
    step();
    drive1(1'b1, 1, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    step();
    @(negedge clk);
    checks++; if (grant !== 2'b00 || m_axis_tvalid !== 1'b0 || s1_axis_tready !== 1'b0) begin errors++; $display("FAIL rstmid_idle: got grant %b vld %b rdy %b want 00 0 0", grant, m_axis_tvalid, s1_axis_tready); end
    checks++; if (pkt_cnt0 !== 3'd0 || pkt_cnt1 !== 3'd0) begin errors++; $display("FAIL rstmid_cnts: got %0d/%0d want 0/0", pkt_cnt0, pkt_cnt1); end
    step();
    rst = 1'b0;
    drive1(1'b0, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic acc;
    int   p;
    p = 0;
    step();
    drive0(1'b1, 0, 1'b1);
    for (int k = 0; k < 18; k++) begin
      @(negedge clk);
      checks++; if (grant !== ((k % 2) ? 2'b01 : 2'b00)) begin errors++; $display("FAIL b2b_grant_c%0d: got %b want %b", k, grant, ((k % 2) ? 2'b01 : 2'b00)); end
      if (k % 2) begin
        checks++; if (m_axis_tdata !== mk_data(0, k / 2)) begin errors++; $display("FAIL b2b_data_c%0d: got %h want %h", k, m_axis_tdata[15:0], 16'(k / 2)); end
      end
      if (k == 16) begin
        checks++; if (pkt_cnt0 !== 3'd0) begin errors++; $display("FAIL b2b_wrap: got %0d want 0", pkt_cnt0); end
      end
      acc = s0_axis_tvalid && s0_axis_tready;
      step();
      if (acc) begin
        p++;
        if (p < 9) drive0(1'b1, p, 1'b1);
        else drive0(1'b0, 0, 1'b0);
      end
    end
    @(negedge clk);
    checks++; if (grant !== 2'b00 || pkt_cnt0 !== 3'd1 || pkt_cnt1 !== 3'd0) begin errors++; $display("FAIL b2b_end: got grant %b cnt %0d/%0d want 00 1/0", grant, pkt_cnt0, pkt_cnt1); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single_beat_s1();
    test_hold_ownership();
    test_tie_arbitration();
    test_ready_stall();
    test_reset_mid_packet();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pcie_rq_arbiter.md
# pcie_rq_arbiter

Packet-granular two-input arbiter sharing the PCIe Requester Request (RQ) AXI-stream between user request traffic (port 0) and the ATS invalidation-completion generator (port 1). It sits directly in front of the PCIe core RQ interface. It grants whole TLPs, never interleaves beats of different packets, and exposes grant state and per-port packet counters for ILA debug.

## Interface

- AXIS_DATA_WIDTH, 512, RQ tdata width; tkeep width is AXIS_DATA_WIDTH/8.
- RQ_AXIS_TUSER_W, 183, RQ tuser width.
- CNT_W, 16, width of each per-port packet counter.

- clk  in  1  single clock domain for all logic.
- rst  in  1  synchronous, active-high reset.
- s0_axis_tdata / tkeep / tuser / tlast / tvalid  in  AXIS_DATA_WIDTH / AXIS_DATA_WIDTH/8 / RQ_AXIS_TUSER_W / 1 / 1  user RQ stream.
- s0_axis_tready  out  1  port 0 ready.
- s1_axis_tdata / tkeep / tuser / tlast / tvalid  in  same widths  ATS completion stream.
- s1_axis_tready  out  1  port 1 ready.
- m_axis_tdata / tkeep / tuser / tlast / tvalid  out  same widths  to PCIe core RQ.
- m_axis_tready  in  1  core ready.
- grant  out  2  one-hot owner: 2'b01 port 0, 2'b10 port 1, 2'b00 idle.
- pkt_cnt0, pkt_cnt1  out  CNT_W each  TLPs completed per port.

## Operation

- FSM states: IDLE, GNT0, GNT1.
- IDLE: m_axis_tvalid=0; all m_axis data fields driven 0; s0/s1 tready=0.
  - Only s0 valid -> GNT0; only s1 valid -> GNT1.
  - Both valid -> round-robin: grant the port not equal to last_served.
- GNTn: m_axis_{tdata,tkeep,tuser,tlast,tvalid} = sn_axis_* (combinational mux); sn_axis_tready = m_axis_tready; the other port's tready=0.
- Packet end: in GNTn, sn_axis_tvalid && m_axis_tready && sn_axis_tlast -> IDLE, last_served<=n, pkt_cntn<=pkt_cntn+1.
- Ownership is held until tlast is accepted; the other port's valid is ignored mid-packet. Sources must hold tvalid and data until accepted, per AXIS rules.
- Valid deasserting mid-packet (a bubble): stay in GNTn and pass the bubble through.
- Counters wrap modulo 2^CNT_W with no saturation.
- grant is a registered decode of the state.

## Timing

- Reset values: state IDLE, last_served=1 (so port 0 wins the first tie), grant=00, pkt_cnt0=pkt_cnt1=0, m_axis_tvalid=0, s0/s1_axis_tready=0, m_axis data fields 0.
- Grant latency: sn_axis_tvalid seen in IDLE at cycle N -> GNTn at cycle N+1; the first beat can be accepted at N+1.
- Zero-cycle datapath: no registers between s and m while granted.
- One IDLE bubble cycle between consecutive packets, including back-to-back packets from the same port.
- Single-beat packet (tlast on the first beat) accepted at cycle N+1 -> IDLE at N+2.
- Counter and last_served update on the same edge that leaves GNTn.
- m_axis_tready low holds the state and all outputs stable.
- rst asserted mid-packet: next edge forces IDLE and clears the counters. The partial packet is abandoned; upstream must also be reset.
- tlast acceptance and new valid on the other port in the same cycle: that port is granted only after the IDLE cycle.

## Configuration

- RQ_ARB_ATS_PRIO_EN defined: on a tie in IDLE, port 1 (ATS completion) always wins; last_served is still tracked but ignored for ties.
- RQ_ARB_ATS_PRIO_EN undefined: round-robin ties as described in Operation.
- Non-tie behaviour is identical in both builds.

## Test plan

- Reset, then a single 1-beat packet on s1 with m_axis_tready=1 -> grant=10 at cycle 1, m_axis_tvalid=1 and tlast=1 at cycle 1, IDLE at cycle 2, pkt_cnt1=1, pkt_cnt0=0.
- 4-beat packet on s0; raise s1 valid at beat 2 -> s1_axis_tready stays 0 and m_axis carries only s0 beats. After s0 tlast there is one IDLE cycle, then grant=10.
- Both ports continuously offer 2-beat packets, without the macro -> grant sequence 01,00,10,00,01,00,10. After 4 packets pkt_cnt0=2 and pkt_cnt1=2.
- Same stimulus with RQ_ARB_ATS_PRIO_EN -> port 1 granted every time; pkt_cnt1 increments and pkt_cnt0 stays 0.
- m_axis_tready toggled 1,0,0,1 during a 3-beat s0 packet -> each beat appears exactly once on m_axis, outputs are stable while ready=0, and pkt_cnt0 increments once.
- rst pulsed at beat 2 of a 4-beat s1 packet -> next cycle grant=00, m_axis_tvalid=0, both counters 0, s1_axis_tready=0.
